digest_unpacker: RTL

Serializes the SHA-256 digest back onto the UART link: accepts the 8×32-bit hash words from the SHA-256 core as a valid-qualified word stream, buffers them, and feeds them one byte at a time (MSB first) to the UART transmitter with a DV/done handshake. Sits between the core's digest output and the UART TX, as the return path that mirrors the byte-to-word packing on the receive side.

---
 rtl/digest_unpacker.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/digest_unpacker.sv
// digest_unpacker
// Return path from the SHA-256 core to the UART transmitter. Collects
// NUM_WORDS digest words from a valid-qualified stream, then hands them to
// the UART one byte at a time: word 0 goes first, and each word is sent most
// significant byte first. A DV/done handshake paces the bytes.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous, active-high reset
//   hash_in        digest word from the SHA-256 core
//   hash_valid     qualifies hash_in; one word accepted per high cycle
//   ready          high while words can be accepted (idle / collecting)
//   Tx_Active      UART TX busy; no byte is launched while high
//   Tx_Done        one-cycle pulse from the UART TX when a byte has finished
//   Tx_DV          one-cycle strobe; uart_byte_out is valid, start sending
//   uart_byte_out  byte for the UART TX, held until the next Tx_DV
//   done           one-cycle pulse after the last byte's Tx_Done
//   overrun        one-cycle pulse when a word arrived while ready was low
module digest_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] hash_in,
  input  logic                  hash_valid,
  output logic                  ready,
  input  logic                  Tx_Active,
  input  logic                  Tx_Done,
  output logic                  Tx_DV,
  output logic [7:0]            uart_byte_out,
  output logic                  done,
  output logic                  overrun
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int NUM_BYTES      = NUM_WORDS * BYTES_PER_WORD;
  localparam int FLAT_W         = NUM_WORDS * DATA_WIDTH;
  localparam int WCNT_W         = $clog2(NUM_WORDS) + 1;
  localparam int WIDX_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BCNT_W         = $clog2(NUM_BYTES) + 1;

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    s_IDLE      = 3'd0,
    s_COLLECT   = 3'd1,
    s_LOAD_BYTE = 3'd2,
    s_WAIT_TX   = 3'd3,
    s_CLEANUP   = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [WCNT_W-1:0]   wcnt_r;
  logic [WCNT_W-1:0]   wcnt_next_s;
  logic [BCNT_W-1:0]   bcnt_r;
  logic [BCNT_W-1:0]   bcnt_next_s;
  logic                store_s;
  logic                launch_s;
  logic                cleanup_s;
  logic                ready_s;
  logic [DATA_WIDTH-1:0] word_buf_r [NUM_WORDS];
  logic [FLAT_W-1:0]   digest_flat_s;
  logic                tx_dv_r;
  logic [7:0]          byte_r;
  logic                done_r;
  logic                overrun_r;

  // Pick byte idx of the digest; byte 0 sits in the top bits of the flat vector.
  function automatic logic [7:0] select_byte(input logic [FLAT_W-1:0] flat,
                                             input logic [BCNT_W-1:0] idx);
    logic [7:0] result;
    result = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (idx == BCNT_W'(i)) begin
        result = flat[(NUM_BYTES - 1 - i) * 8 +: 8];
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // Words are accepted only while idle/collecting. The done cycle is also
  // excluded, so a new digest cannot start before the host has seen done.
  always_comb begin
    ready_s = ((state_r == s_IDLE) || (state_r == s_COLLECT)) && !done_r;
  end

  // Flatten the buffer with word 0 in the most significant position.
  always_comb begin
    digest_flat_s = {FLAT_W{1'b0}};
    for (int w = 0; w < NUM_WORDS; w++) begin
      digest_flat_s[(NUM_WORDS - 1 - w) * DATA_WIDTH +: DATA_WIDTH] = word_buf_r[w];
    end
  end

  // Next-state and counter logic for the collect / transmit sequence.
  always_comb begin
    state_next_s = state_r;
    wcnt_next_s  = wcnt_r;
    bcnt_next_s  = bcnt_r;
    store_s      = 1'b0;
    launch_s     = 1'b0;
    cleanup_s    = 1'b0;
    case (state_r)
      // wcnt is zero in idle, so the first word lands in slot 0.
      s_IDLE, s_COLLECT: begin
        if (hash_valid && ready_s) begin
          store_s     = 1'b1;
          wcnt_next_s = wcnt_r + WCNT_W'(1);
          if (wcnt_r == LAST_WORD) begin
            state_next_s = s_LOAD_BYTE;
          end else begin
            state_next_s = s_COLLECT;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      s_LOAD_BYTE: begin
        if (!Tx_Active) begin
          launch_s     = 1'b1;
          state_next_s = s_WAIT_TX;
        end else begin
          state_next_s = s_LOAD_BYTE;
        end
      end
      // A Tx_Done coinciding with our own Tx_DV belongs to an older byte.
      s_WAIT_TX: begin
        if (Tx_Done && !tx_dv_r) begin
          if (bcnt_r == LAST_BYTE) begin
            state_next_s = s_CLEANUP;
          end else begin
            bcnt_next_s  = bcnt_r + BCNT_W'(1);
            state_next_s = s_LOAD_BYTE;
          end
        end else begin
          state_next_s = s_WAIT_TX;
        end
      end
      s_CLEANUP: begin
        cleanup_s    = 1'b1;
        wcnt_next_s  = {WCNT_W{1'b0}};
        bcnt_next_s  = {BCNT_W{1'b0}};
        state_next_s = s_IDLE;
      end
      default: begin
        wcnt_next_s  = {WCNT_W{1'b0}};
        bcnt_next_s  = {BCNT_W{1'b0}};
        state_next_s = s_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= s_IDLE;
      wcnt_r  <= {WCNT_W{1'b0}};
      bcnt_r  <= {BCNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      wcnt_r  <= wcnt_next_s;
      bcnt_r  <= bcnt_next_s;
    end
  end

  // Registered handshake outputs; the byte register only moves on a launch.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_dv_r   <= 1'b0;
      byte_r    <= 8'h00;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      tx_dv_r   <= launch_s;
      done_r    <= cleanup_s;
      overrun_r <= hash_valid && !ready_s;
      if (launch_s) begin
        byte_r <= select_byte(digest_flat_s, bcnt_r);
      end else begin
        byte_r <= byte_r;
      end
    end
  end

  // Digest buffer; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (store_s && !rst) begin
      word_buf_r[wcnt_r[WIDX_W-1:0]] <= hash_in;
    end
  end

  assign ready         = ready_s;
  assign Tx_DV         = tx_dv_r;
  assign uart_byte_out = byte_r;
  assign done          = done_r;
  assign overrun       = overrun_r;

endmodule
